// File: rtl/dice_pkg.sv
// Types shared between the dice turn receiver and the game FSM.
package dice_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        RED   = 2'd1,
        GREEN = 2'd2,
        BLUE  = 2'd3
    } color_e;

    typedef enum logic [1:0] {
        ARM        = 2'd0,
        WAIT_ROLL  = 2'd1,
        PRESENT    = 2'd2,
        WAIT_CLEAR = 2'd3
    } turn_state_e;

    localparam logic [7:0] REJECT_SAT = 8'hFF;

endpackage

// File: rtl/color_step_lut.sv
// Combinational dice color to step count mapping; NONE grants no steps.
module color_step_lut
    import dice_pkg::*;
#(
    parameter logic [2:0] RED_STEPS   = 3'd1,
    parameter logic [2:0] GREEN_STEPS = 3'd2,
    parameter logic [2:0] BLUE_STEPS  = 3'd3
) (
    input  color_e     color,
    output logic [2:0] steps
);

    always_comb begin
        steps = 3'd0;
        case (color)
            RED:     steps = RED_STEPS;
            GREEN:   steps = GREEN_STEPS;
            BLUE:    steps = BLUE_STEPS;
            default: steps = 3'd0;
        endcase
    end

endmodule

// File: rtl/dice_turn_receiver.sv
// Turns color detector pulses into one qualified move per roll, offers it to the
// game FSM on valid/ready, then waits for the table to clear and rotates players.
module dice_turn_receiver
    import dice_pkg::*;
#(
    parameter int          NUM_PLAYERS   = 2,
    parameter logic [15:0] MIN_CONF      = 16'd150,
    parameter logic [2:0]  RED_STEPS     = 3'd1,
    parameter logic [2:0]  GREEN_STEPS   = 3'd2,
    parameter logic [2:0]  BLUE_STEPS    = 3'd3,
    parameter logic [31:0] CLEAR_TIMEOUT = 32'd50_000_000,
    parameter int          PW            = $clog2(NUM_PLAYERS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [1:0]    stable_color,
    input  logic          result_ready,
    input  logic          turn_end,
    input  logic          current_state_white,
    input  logic [15:0]   stable_confidence,
    output logic          move_valid,
    input  logic          move_ready,
    output logic [2:0]    move_steps,
    output logic [PW-1:0] move_player,
    output logic [PW-1:0] cur_player,
    output logic          stall,
    output logic [7:0]    reject_cnt,
    output logic [1:0]    state_dbg
);

    color_e          color_reg;
    logic            result_ready_reg;
    logic            turn_end_reg;
    logic            white_reg;
    logic [15:0]     conf_reg;

    turn_state_e     state_reg;
    logic            move_valid_reg;
    logic [2:0]      move_steps_reg;
    logic [PW-1:0]   move_player_reg;
    logic [PW-1:0]   cur_player_reg;
    logic            stall_reg;
    logic [7:0]      reject_cnt_reg;
    logic [31:0]     clear_cnt_reg;

    logic [2:0]      lut_steps;
    logic            roll_ok;
    logic [7:0]      reject_cnt_next;
    logic [31:0]     clear_cnt_next;
    logic [PW-1:0]   cur_player_next;

    color_step_lut #(
        .RED_STEPS  (RED_STEPS),
        .GREEN_STEPS(GREEN_STEPS),
        .BLUE_STEPS (BLUE_STEPS)
    ) u_lut (
        .color(color_reg),
        .steps(lut_steps)
    );

    always_comb begin
        roll_ok         = (color_reg != NONE) && (conf_reg >= MIN_CONF);
        reject_cnt_next = (reject_cnt_reg == REJECT_SAT) ? reject_cnt_reg : reject_cnt_reg + 8'd1;
        clear_cnt_next  = (clear_cnt_reg == CLEAR_TIMEOUT) ? clear_cnt_reg : clear_cnt_reg + 32'd1;
        cur_player_next = (cur_player_reg == PW'(NUM_PLAYERS - 1)) ? '0 : cur_player_reg + PW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            color_reg        <= NONE;
            result_ready_reg <= 1'b0;
            turn_end_reg     <= 1'b0;
            white_reg        <= 1'b0;
            conf_reg         <= 16'd0;
            state_reg        <= ARM;
            move_valid_reg   <= 1'b0;
            move_steps_reg   <= 3'd0;
            move_player_reg  <= '0;
            cur_player_reg   <= '0;
            stall_reg        <= 1'b0;
            reject_cnt_reg   <= 8'd0;
            clear_cnt_reg    <= 32'd0;
        end else begin
            color_reg        <= color_e'(stable_color);
            result_ready_reg <= result_ready;
            turn_end_reg     <= turn_end;
            white_reg        <= current_state_white;
            conf_reg         <= stable_confidence;

            case (state_reg)
                ARM: begin
                    if (result_ready_reg)
                        reject_cnt_reg <= reject_cnt_next;
                    if (white_reg)
                        state_reg <= WAIT_ROLL;
                end
                WAIT_ROLL: begin
                    if (result_ready_reg) begin
                        if (roll_ok) begin
                            move_steps_reg  <= lut_steps;
                            move_player_reg <= cur_player_reg;
                            move_valid_reg  <= 1'b1;
                            state_reg       <= PRESENT;
                        end else begin
                            reject_cnt_reg <= reject_cnt_next;
                        end
                    end
                end
                PRESENT: begin
                    if (result_ready_reg)
                        reject_cnt_reg <= reject_cnt_next;
                    if (move_valid_reg && move_ready) begin
                        move_valid_reg <= 1'b0;
                        clear_cnt_reg  <= 32'd0;
                        stall_reg      <= 1'b0;
                        state_reg      <= WAIT_CLEAR;
                    end
                end
                WAIT_CLEAR: begin
                    if (result_ready_reg)
                        reject_cnt_reg <= reject_cnt_next;
                    if (turn_end_reg) begin
                        cur_player_reg <= cur_player_next;
                        clear_cnt_reg  <= 32'd0;
                        stall_reg      <= 1'b0;
                        state_reg      <= WAIT_ROLL;
                    end else begin
                        // counter parks at the timeout so stall stays up until turn_end
                        clear_cnt_reg <= clear_cnt_next;
                        stall_reg     <= (clear_cnt_next == CLEAR_TIMEOUT);
                    end
                end
                default: state_reg <= ARM;
            endcase
        end
    end

    assign move_valid  = move_valid_reg;
    assign move_steps  = move_steps_reg;
    assign move_player = move_player_reg;
    assign cur_player  = cur_player_reg;
    assign stall       = stall_reg;
    assign reject_cnt  = reject_cnt_reg;
    assign state_dbg   = state_reg;

endmodule
